// File: rtl/uart_rx_if.sv
// RX-side push bus between the UART receive engine and the RX FIFO / status logic.
// master = receiver (drives byte + status strobes), slave = FIFO/LSR side.
interface uart_rx_if;
   logic [7:0] rx_data_o;
   logic       rx_valid_o;
   logic       framing_err_o;
   logic       break_o;
   logic       overrun_err_o;
   logic       fifo_full_i;

   modport master (
      output rx_data_o, rx_valid_o, framing_err_o, break_o, overrun_err_o,
      input  fifo_full_i
   );

   modport slave (
      input  rx_data_o, rx_valid_o, framing_err_o, break_o, overrun_err_o,
      output fifo_full_i
   );
endinterface

// File: rtl/uart_rx.sv
// UART 8N1 receive engine: rx_i synchroniser, {DLM,DLL} tick divider, 16x oversampled FSM, FIFO push.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote of samples at scnt 6,7,8 instead of a single sample at 7.
module uart_rx #(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] DLM,
   input  logic [7:0] DLL,
   input  logic       rx_i,
   output logic       busy_o,
   uart_rx_if.master  fifo
);

   localparam logic [3:0] SCNT_LAST = 4'(OVERSAMPLE - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;
   logic [15:0]            div;
   logic [15:0]            cnt;
   logic                   tick;
   logic [3:0]             scnt;
   logic [2:0]             bitcnt;
   logic [7:0]             shreg;
   logic                   armed;
   logic                   sample;
   logic                   bit_val;

   logic [7:0]             rx_data_q;
   logic                   rx_valid_q;
   logic                   framing_q;
   logic                   break_q;
   logic                   overrun_q;

   // Idle-high line: synchroniser resets to 1 so reset release never looks like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '1;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
   end
   assign rx_s = sync_q[SYNC_STAGES-1];

   // >= rather than == so a divisor shrunk mid-count still wraps on the next cycle.
   assign div  = {DLM, DLL};
   assign tick = (div != 16'd0) && (cnt >= div - 16'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   cnt <= '0;
      else if (div == 16'd0 || tick) cnt <= '0;
      else                          cnt <= cnt + 16'd1;
   end

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] vote_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         vote_q <= '0;
      else if (tick && state != IDLE && (scnt == 4'd6 || scnt == 4'd7))
         vote_q <= {vote_q[0], rx_s};
   end

   // Third vote is the live sample at scnt 8, so the decision lands on that tick.
   assign sample  = (scnt == 4'd8);
   assign bit_val = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx_s) | (vote_q[0] & rx_s);
`else
   assign sample  = (scnt == 4'd7);
   assign bit_val = rx_s;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         scnt       <= '0;
         bitcnt     <= '0;
         shreg      <= '0;
         armed      <= 1'b1;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         framing_q  <= 1'b0;
         break_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         framing_q  <= 1'b0;
         break_q    <= 1'b0;
         overrun_q  <= 1'b0;
         if (div == 16'd0) begin
            state  <= IDLE;
            scnt   <= '0;
            bitcnt <= '0;
         end else if (tick) begin
            scnt <= scnt + 4'd1;
            case (state)
               IDLE: begin
                  scnt <= '0;
                  if (rx_s)       armed <= 1'b1;
                  else if (armed) state <= START;
               end
               START: begin
                  if (sample && bit_val) begin
                     state <= IDLE;
                  end else if (scnt == SCNT_LAST) begin
                     state  <= DATA;
                     bitcnt <= '0;
                  end
               end
               DATA: begin
                  if (sample) shreg <= {bit_val, shreg[7:1]};
                  if (scnt == SCNT_LAST) begin
                     if (bitcnt == 3'd7) state  <= STOP;
                     else                bitcnt <= bitcnt + 3'd1;
                  end
               end
               STOP: begin
                  // Leave mid-stop so the next start edge can be caught half a bit early.
                  if (sample) begin
                     rx_data_q  <= shreg;
                     rx_valid_q <= !fifo.fifo_full_i;
                     overrun_q  <= fifo.fifo_full_i;
                     framing_q  <= !bit_val;
                     break_q    <= !bit_val && (shreg == 8'h00);
                     if (!bit_val) armed <= 1'b0;
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign fifo.rx_data_o     = rx_data_q;
   assign fifo.rx_valid_o    = rx_valid_q;
   assign fifo.framing_err_o = framing_q;
   assign fifo.break_o       = break_q;
   assign fifo.overrun_err_o = overrun_q;
   assign busy_o             = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of framed bytes, randomized frames against a frame-level model,
// and hand sequences for glitch, back-to-back, break, stop-0 rearm, divisor 0 and mid-frame reset.
module tb_uart_rx;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] dlm = 8'h00;
   logic [7:0] dll = 8'h01;
   logic       rx_i = 1'b1;
   logic       busy;

   uart_rx_if fif();

   uart_rx dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .DLM    (dlm),
      .DLL    (dll),
      .rx_i   (rx_i),
      .busy_o (busy),
      .fifo   (fif.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       valid;
      logic       fe;
      logic       brk;
      logic       ovr;
   } ev_t;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       full;
      int         div;
      ev_t        exp;
   } vec_t;

   ev_t evq[$];
   int  nvec = 0;
   int  nerr = 0;
   bit  meas = 0;
   int  lowrun = 0;
   int  maxlow = 0;

   // Every cycle carrying any strobe becomes one event; a stretched pulse shows up as two.
   always @(negedge clk) begin
      if (fif.rx_valid_o | fif.overrun_err_o | fif.framing_err_o | fif.break_o)
         evq.push_back('{fif.rx_data_o, fif.rx_valid_o, fif.framing_err_o, fif.break_o, fif.overrun_err_o});
      if (!meas) begin
         lowrun <= 0;
         maxlow <= 0;
      end else if (!busy) begin
         lowrun <= lowrun + 1;
         if (lowrun + 1 > maxlow) maxlow <= lowrun + 1;
      end else begin
         lowrun <= 0;
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic set_div(input int d);
      dlm = 8'(d >> 8);
      dll = 8'(d);
   endtask

   task automatic hold(input logic v, input int clks);
      rx_i = v;
      repeat (clks) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input int div);
      logic [7:0] b;
      b = d;
      hold(1'b0, 16 * div);
      for (int i = 0; i < 8; i++) hold(b[i], 16 * div);
      hold(stop, 16 * div);
   endtask

   // Frame-level reference: what a correct 8N1 receiver reports for one frame.
   function automatic ev_t model(input logic [7:0] d, input logic stop, input logic full);
      ev_t e;
      e.data  = d;
      e.valid = !full;
      e.ovr   = full;
      e.fe    = !stop;
      e.brk   = !stop && (d == 8'h00);
      return e;
   endfunction

   task automatic expect_one(input string name, input ev_t e);
      chk({name, ".events"}, evq.size(), 1);
      if (evq.size() >= 1) begin
         chk({name, ".data"},  evq[0].data,  e.data);
         chk({name, ".valid"}, evq[0].valid, e.valid);
         chk({name, ".fe"},    evq[0].fe,    e.fe);
         chk({name, ".brk"},   evq[0].brk,   e.brk);
         chk({name, ".ovr"},   evq[0].ovr,   e.ovr);
      end
      evq.delete();
   endtask

   task automatic chk_quiet(input string name);
      chk({name, ".data"},  fif.rx_data_o,     0);
      chk({name, ".valid"}, fif.rx_valid_o,    0);
      chk({name, ".fe"},    fif.framing_err_o, 0);
      chk({name, ".brk"},   fif.break_o,       0);
      chk({name, ".ovr"},   fif.overrun_err_o, 0);
      chk({name, ".busy"},  busy,              0);
   endtask

   vec_t vt[8];

   initial begin
      // Expected values hand-derived from the frame format: {data, valid, fe, brk, ovr}.
      vt[0] = '{8'h55, 1'b1, 1'b0, 1, '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0}};
      vt[1] = '{8'hF0, 1'b0, 1'b0, 1, '{8'hF0, 1'b1, 1'b1, 1'b0, 1'b0}};
      vt[2] = '{8'h81, 1'b1, 1'b1, 1, '{8'h81, 1'b0, 1'b0, 1'b0, 1'b1}};
      vt[3] = '{8'h00, 1'b0, 1'b0, 2, '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0}};
      vt[4] = '{8'h00, 1'b1, 1'b0, 3, '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0}};
      vt[5] = '{8'hFF, 1'b1, 1'b0, 1, '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0}};
      vt[6] = '{8'h81, 1'b0, 1'b1, 2, '{8'h81, 1'b0, 1'b1, 1'b0, 1'b1}};
      vt[7] = '{8'h3C, 1'b1, 1'b0, 4, '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0}};

      fif.fifo_full_i = 1'b0;
      repeat (3) @(negedge clk);
      chk_quiet("reset");
      rst_n = 1'b1;
      hold(1'b1, 20);

      for (int i = 0; i < 8; i++) begin
         set_div(vt[i].div);
         fif.fifo_full_i = vt[i].full;
         send_frame(vt[i].data, vt[i].stop, vt[i].div);
         hold(1'b1, 16 * vt[i].div);
         fif.fifo_full_i = 1'b0;
         expect_one($sformatf("table%0d", i), vt[i].exp);
      end

      for (int n = 0; n < 30; n++) begin
         logic [7:0] d;
         logic       st;
         logic       fl;
         int         dv;
         int         gap;
         d   = 8'($urandom);
         st  = ($urandom_range(0, 3) != 0);
         fl  = ($urandom_range(0, 3) == 0);
         dv  = $urandom_range(1, 3);
         gap = st ? $urandom_range(0, 2) : $urandom_range(1, 2);
         set_div(dv);
         fif.fifo_full_i = fl;
         send_frame(d, st, dv);
         hold(1'b1, 16 * dv * gap);
         expect_one($sformatf("rand%0d", n), model(d, st, fl));
      end
      fif.fifo_full_i = 1'b0;
      hold(1'b1, 64);
      evq.delete();

      // Back-to-back frames at div 4; busy may only drop for the tail of each stop bit.
      set_div(4);
      hold(1'b1, 64);
      meas = 1;
      send_frame(8'hA5, 1'b1, 4);
      send_frame(8'h3C, 1'b1, 4);
      chk("b2b.maxlow_le_32", int'(maxlow <= 32), 1);
      chk("b2b.busy_dropped", int'(maxlow > 0), 1);
      meas = 0;
      chk("b2b.events", evq.size(), 2);
      if (evq.size() == 2) begin
         chk("b2b.first",  evq[0].data, 8'hA5);
         chk("b2b.second", evq[1].data, 8'h3C);
         chk("b2b.valid",  int'(evq[0].valid & evq[1].valid), 1);
      end
      evq.delete();

      // Start glitch shorter than half a bit.
      set_div(1);
      hold(1'b1, 32);
      hold(1'b0, 4);
      hold(1'b1, 2);
      chk("glitch.busy_mid", busy, 1);
      hold(1'b1, 10);
      chk("glitch.busy_end", busy, 0);
      hold(1'b1, 200);
      chk("glitch.events", evq.size(), 0);
      evq.delete();

      // Stop bit 0 followed immediately by another start: ignored until the line goes high.
      send_frame(8'hF0, 1'b0, 1);
      hold(1'b0, 16);
      hold(1'b1, 16 * 12);
      expect_one("stop0_rearm", '{8'hF0, 1'b1, 1'b1, 1'b0, 1'b0});

      // Line held low 30 bit times.
      hold(1'b0, 16 * 30);
      hold(1'b1, 16 * 4);
      expect_one("break", '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0});

      // Divisor 0 stops the receiver entirely.
      set_div(0);
      send_frame(8'h12, 1'b1, 1);
      hold(1'b1, 32);
      chk("div0.events", evq.size(), 0);
      chk("div0.busy", busy, 0);
      evq.delete();

      // Reset in the middle of the data bits of a 0x81 frame.
      set_div(1);
      hold(1'b1, 32);
      hold(1'b0, 16);
      hold(1'b1, 16);
      hold(1'b0, 20);
      rst_n = 1'b0;
      #1;
      chk_quiet("rst_mid");
      hold(1'b1, 5);
      rst_n = 1'b1;
      hold(1'b1, 300);
      chk("rst_mid.events", evq.size(), 0);
      chk("rst_mid.data_after", fif.rx_data_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
